// File: rtl/seq_detector_pkg.sv
// Shared types for the serial 1011 detector and the arbiter that scans words through it.
package seq_detector_pkg;

    typedef enum logic [2:0] {
        S0,
        S1,
        S2,
        S3,
        S4
    } state_t;

    typedef enum logic [2:0] {
        SC_IDLE,
        SC_CLEAR,
        SC_SHIFT,
        SC_DRAIN,
        SC_RESP
    } scan_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: the requester that was not granted last wins a tie.
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o    = 2'b00;
        grant_o[0] = valid_i[0] & (~valid_i[1] | last_grant_i);
        grant_o[1] = valid_i[1] & (~valid_i[0] | ~last_grant_i);
    end

endmodule

// File: rtl/seq_scan_arbiter.sv
// Shares one serial 1011 detector between two word requesters: clear, shift MSB-first,
// count hits and hand the count back tagged with the requester id.
module seq_scan_arbiter
    import seq_detector_pkg::*;
#(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned CNT_W  = $clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [WORD_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [WORD_W-1:0] req1_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [CNT_W-1:0]  resp_count,
    output logic              det_rst_n,
    output logic              det_bit,
    input  logic              det_hit
);

    localparam int unsigned BIT_W = $clog2(WORD_W);

    scan_state_t       state_q, state_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
    logic              id_q, id_d;
    logic              last_grant_q, last_grant_d;
    logic              det_rst_n_q, det_rst_n_d;
    logic              det_bit_q, det_bit_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_id_q, resp_id_d;
    logic [CNT_W-1:0]  resp_count_q, resp_count_d;
    logic [1:0]        grant;

    rr_arb2 u_arb (
        .valid_i      ({req1_valid, req0_valid}),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SC_IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            hit_cnt_q    <= '0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            det_rst_n_q  <= 1'b0;
            det_bit_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_count_q <= '0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            hit_cnt_q    <= hit_cnt_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            det_rst_n_q  <= det_rst_n_d;
            det_bit_q    <= det_bit_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_count_q <= resp_count_d;
        end
    end

    // Registered detector controls are computed one cycle ahead of the state that owns them.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        hit_cnt_d    = hit_cnt_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        det_rst_n_d  = det_rst_n_q;
        det_bit_d    = det_bit_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_count_d = resp_count_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;

        case (state_q)
            SC_IDLE: begin
                det_rst_n_d = 1'b1;
                det_bit_d   = 1'b0;
                if (|grant) begin
                    req0_ready   = grant[0] & ~rst;
                    req1_ready   = grant[1] & ~rst;
                    shreg_d      = grant[1] ? req1_data : req0_data;
                    id_d         = grant[1];
                    last_grant_d = grant[1];
                    bit_cnt_d    = '0;
                    hit_cnt_d    = '0;
                    det_rst_n_d  = 1'b0;
                    state_d      = SC_CLEAR;
                end
            end
            SC_CLEAR: begin
                det_rst_n_d = 1'b1;
                det_bit_d   = shreg_q[WORD_W-1];
                shreg_d     = {shreg_q[WORD_W-2:0], 1'b0};
                state_d     = SC_SHIFT;
            end
            SC_SHIFT: begin
                // det_hit lags the driven bit by one cycle, so bit 0 has no sample yet.
                if (bit_cnt_q != '0) begin
                    hit_cnt_d = hit_cnt_q + CNT_W'(det_hit);
                end
                if (bit_cnt_q == BIT_W'(WORD_W - 1)) begin
                    det_bit_d = 1'b0;
                    state_d   = SC_DRAIN;
                end else begin
                    det_bit_d = shreg_q[WORD_W-1];
                    shreg_d   = {shreg_q[WORD_W-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end
            end
            SC_DRAIN: begin
                hit_cnt_d    = hit_cnt_q + CNT_W'(det_hit);
                resp_count_d = hit_cnt_q + CNT_W'(det_hit);
                resp_id_d    = id_q;
                resp_valid_d = 1'b1;
                state_d      = SC_RESP;
            end
            SC_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = SC_IDLE;
                end
            end
            default: begin
                state_d = SC_IDLE;
            end
        endcase
    end

    assign det_rst_n  = det_rst_n_q;
    assign det_bit    = det_bit_q;
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_count = resp_count_q;

endmodule
